// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions used by the register-dump path.
// Contents: register word width, register-address width, and the
// state encoding of the register-dump reader FSM.
package kgp_risc_pkg;

  localparam int KGP_DATA_W     = 32;
  localparam int KGP_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams a contiguous range of register-file entries
// out over a valid/ready interface, one beat per register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 dump request (sampled in IDLE only)
//   abort                 cancel a dump in progress
//   first_addr, last_addr inclusive register range, sampled with start
//   rd_addr / rd_data     register-file read port (rd_data combinational)
//   out_valid/out_ready   beat handshake
//   out_data, out_addr    captured register value and its index
//   out_last              beat carries last_addr
//   busy                  high whenever the FSM is not in IDLE
//   done                  one-cycle pulse after a normal completion
//   err                   one-cycle pulse when start carries first > last
module reg_dump_reader
  import kgp_risc_pkg::*;
#(
  parameter int DATA_W = KGP_DATA_W,
  parameter int ADDR_W = KGP_REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dump_state_e       r_state, w_next;

  logic [ADDR_W-1:0] r_cnt,      w_cnt_d;
  logic [ADDR_W-1:0] r_last,     w_last_d;
  logic [DATA_W-1:0] r_out_data, w_out_data_d;
  logic [ADDR_W-1:0] r_out_addr, w_out_addr_d;
  logic              r_out_last, w_out_last_d;
  logic              r_valid,    w_valid_d;
  logic              r_busy,     w_busy_d;
  logic              r_done,     w_done_d;
  logic              r_err,      w_err_d;

  logic              w_range_ok;
  assign w_range_ok = (first_addr <= last_addr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start && w_range_ok) w_next = ST_READ;
      ST_READ: w_next = abort ? ST_IDLE : ST_SEND;
      ST_SEND: begin
        if (abort)          w_next = ST_IDLE;
        else if (out_ready) w_next = r_out_last ? ST_DONE : ST_READ;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below.
  // done is raised on leaving DONE so that an abort seen in DONE can
  // still suppress it.
  always_comb begin
    w_cnt_d      = r_cnt;
    w_last_d     = r_last;
    w_out_data_d = r_out_data;
    w_out_addr_d = r_out_addr;
    w_out_last_d = r_out_last;
    w_valid_d    = r_valid;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    w_busy_d     = (w_next != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_range_ok) begin
            w_cnt_d  = first_addr;
            w_last_d = last_addr;
          end else begin
            w_err_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!abort) begin
          w_out_data_d = rd_data;
          w_out_addr_d = r_cnt;
          w_out_last_d = (r_cnt == r_last);
          w_valid_d    = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          w_valid_d = 1'b0;
        end else if (out_ready) begin
          w_valid_d = 1'b0;
          // The last beat never advances the counter, so 31 cannot wrap.
          if (!r_out_last) w_cnt_d = r_cnt + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        if (!abort) w_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_last     <= '0;
      r_out_data <= '0;
      r_out_addr <= '0;
      r_out_last <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_last     <= w_last_d;
      r_out_data <= w_out_data_d;
      r_out_addr <= w_out_addr_d;
      r_out_last <= w_out_last_d;
      r_valid    <= w_valid_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  assign rd_addr   = r_cnt;
  assign out_valid = r_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed scenarios plus
// randomized ranges/backpressure checked against a queue of expected beats.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [4:0]  first_addr, last_addr, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done, err;

  logic [31:0] rf [32];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if ({rd_addr, out_data, out_addr, out_valid, out_last, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL %s: rd_addr=%0d out_data=%h out_addr=%0d valid=%b last=%b busy=%b done=%b err=%b, required all 0",
               tag, rd_addr, out_data, out_addr, out_valid, out_last, busy, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    preload_pattern();
    tick(); tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    tick();
    check_all_zero("idle_after_reset");
  endtask

  // Beat check used inline by directed tests: expected address/last are explicit.
  task automatic test_dump_range();
    out_ready = 1'b1;
    first_addr = 5'd2; last_addr = 5'd4; start = 1'b1;
    tick(); start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rd_addr !== 5'd2) begin
      n_err++;
      $display("FAIL latency_edge1: busy=%b valid=%b rd_addr=%0d, required 1/0/2", busy, out_valid, rd_addr);
    end
    for (int b = 2; b <= 4; b++) begin
      if (b > 2) tick();
      if (b == 3) begin
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
      end
      tick(); start = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_addr !== 5'(b) || out_data !== 32'(b * 32'h11) ||
          out_last !== (b == 4)) begin
        n_err++;
        $display("FAIL dump_beat%0d: valid=%b addr=%0d data=%h last=%b, required 1/%0d/%h/%b",
                 b, out_valid, out_addr, out_data, out_last, b, b * 32'h11, b == 4);
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dump_in_done: busy=%b done=%b valid=%b, required 1/0/0", busy, done, out_valid);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_addr !== 5'd4) begin
      n_err++;
      $display("FAIL dump_done: done=%b busy=%b rd_addr=%0d, required 1/0/4", done, busy, rd_addr);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL dump_done_pulse: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    first_addr = 5'd0; last_addr = 5'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'h0 || out_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b addr=%0d data=%h last=%b, required 1/0/0/0",
                 c, out_valid, out_addr, out_data, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: valid=%b, required 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_addr !== 5'd1 || out_data !== 32'h11 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL bp_beat1: valid=%b addr=%0d data=%h last=%b, required 1/1/11/1",
               out_valid, out_addr, out_data, out_last);
    end
    tick(); tick();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL bp_done: done=%b, required 1", done);
    end
    tick();
  endtask

  task automatic test_range_error();
    logic [4:0] ra_before;
    ra_before = rd_addr;
    first_addr = 5'd7; last_addr = 5'd3; start = 1'b1;
    tick(); start = 1'b0;
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rd_addr !== ra_before) begin
      n_err++;
      $display("FAIL range_err: err=%b busy=%b valid=%b rd_addr=%0d, required 1/0/0/%0d",
               err, busy, out_valid, rd_addr, ra_before);
    end
    tick();
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL range_err_pulse: err=%b busy=%b valid=%b, required 0/0/0", err, busy, out_valid);
    end
  endtask

  // Randomized dump: reference is a queue of expected addresses built
  // from the range; data comes from the bench's copy of the register file.
  task automatic run_dump(input int f, input int l, input int rdy_pct, input bit poke_start,
                          input string tag);
    int          exp_q[$];
    bit          held;
    logic [31:0] h_data;
    logic [4:0]  h_addr;
    logic        h_last;
    int          done_seen;
    int          a;
    for (int i = f; i <= l; i++) exp_q.push_back(i);
    held = 1'b0; done_seen = 0; h_data = '0; h_addr = '0; h_last = 1'b0;
    first_addr = 5'(f); last_addr = 5'(l); start = 1'b1;
    out_ready = 1'b0;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 1500 && done_seen == 0; cyc++) begin
      if (done === 1'b1) begin
        done_seen = 1;
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s_done: remaining beats=%0d busy=%b, required 0/0", tag, exp_q.size(), busy);
        end
      end else begin
        if (held) begin
          n_vec++;
          if (out_valid !== 1'b1 || out_data !== h_data || out_addr !== h_addr || out_last !== h_last) begin
            n_err++;
            $display("FAIL %s_stable: valid=%b addr=%0d data=%h last=%b, required 1/%0d/%h/%b",
                     tag, out_valid, out_addr, out_data, out_last, h_addr, h_data, h_last);
          end
        end
        out_ready = ($urandom_range(99, 0) < rdy_pct);
        if (out_valid === 1'b1 && out_ready) begin
          a = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
          n_vec++;
          if (a < 0 || out_addr !== 5'(a) || out_data !== rf[a] || out_last !== (a == l)) begin
            n_err++;
            $display("FAIL %s_beat: addr=%0d data=%h last=%b, required %0d/%h/%b",
                     tag, out_addr, out_data, out_last, a, (a < 0) ? 32'h0 : rf[a], a == l);
          end
          held = 1'b0;
        end else if (out_valid === 1'b1) begin
          held = 1'b1; h_data = out_data; h_addr = out_addr; h_last = out_last;
        end else begin
          held = 1'b0;
        end
        if (poke_start && busy === 1'b1 && $urandom_range(3, 0) == 0) begin
          start = 1'b1;
          first_addr = 5'($urandom_range(31, 0));
          last_addr  = 5'($urandom_range(31, 0));
        end
        tick();
        start = 1'b0;
      end
    end
    if (done_seen == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: done=0 after cycle budget, required done pulse", tag);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_once: done=%b, required 0", tag, done);
    end
  endtask

  task automatic test_boundary();
    rf[31] = 32'hDEADBEEF;
    run_dump(31, 31, 100, 1'b0, "boundary");
    n_vec++;
    if (rd_addr !== 5'd31 || out_addr !== 5'd31 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL boundary_nowrap: rd_addr=%0d out_addr=%0d last=%b, required 31/31/1",
               rd_addr, out_addr, out_last);
    end
  endtask

  task automatic test_abort();
    int beats;
    preload_pattern();
    out_ready = 1'b1; beats = 0;
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    tick(); start = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 6; cyc++) begin
      if (out_valid === 1'b1) beats++;
      tick();
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || beats != 6) begin
      n_err++;
      $display("FAIL abort_read: valid=%b busy=%b beats=%0d, required 0/0/6", out_valid, busy, beats);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_nodone%0d: done=%b valid=%b, required 0/0", c, done, out_valid);
      end
    end
    // Abort coinciding with a handshake in SEND.
    out_ready = 1'b0; first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    out_ready = 1'b1; abort = 1'b1;
    tick(); abort = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_send: valid=%b busy=%b, required 0/0", out_valid, busy);
    end
    // Abort in DONE suppresses the done pulse.
    first_addr = 5'd3; last_addr = 5'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_done: done=%b busy=%b, required 0/0", done, busy);
    end
    // Abort and start together in IDLE: start wins.
    abort = 1'b1; start = 1'b1; first_addr = 5'd8; last_addr = 5'd9;
    tick(); abort = 1'b0; start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || rd_addr !== 5'd8) begin
      n_err++;
      $display("FAIL abort_start_idle: busy=%b rd_addr=%0d, required 1/8", busy, rd_addr);
    end
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1; first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check_all_zero("rst_mid");
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_quiet%0d: done=%b err=%b busy=%b valid=%b, required 0/0/0/0",
                 c, done, err, busy, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int f, l;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      f = $urandom_range(31, 0);
      l = $urandom_range(31, f);
      run_dump(f, l, $urandom_range(100, 30), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_dump_range();
    test_backpressure();
    test_range_error();
    test_boundary();
    test_abort();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
